mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It consumes that register's access fields and drives the data-side request/address/data handshake. It holds the pipeline with `mem_stall` while an access is outstanding. It then delivers an aligned, extended load result to the MEM/WB register.

## Interface
- `NUM_EX`: codebase-wide macro, default 16. It sets the exception-vector width (`EXBITS` = `NUM_EX-1:0`).
- `clk` in 1: clock. Every register is updated on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `refresh` in 1: pipeline flush on exception or eret. It is the same signal that clears EX/MEM.
- `stall_in` in 1: hold request from a later stage or from the fetch side.
- `mem_ex` in `EXBITS`: exception vector of the instruction in MEM. A non-zero value suppresses the access.
- `mem_res` in 32: effective address.
- `mem_data_en` in 1: access valid.
- `mem_data_ren` in 4: byte-lane read mask. Legal values are 0001/0010/0100/1000/0011/1100/1111.
- `mem_data_wen` in 4: byte-lane write mask. Same legal values as the read mask.
- `mem_wdata` in 32: store data, already lane-aligned by EX.
- `mem_loadX` in 1: 1 = sign-extend the load, 0 = zero-extend.
- `data_req` out 1: request valid.
- `data_wr` out 1: 1 = store.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` out 32: request address.
- `data_wstrb` out 4: write strobe.
- `data_wdata` out 32: store data.
- `data_addr_ok` in 1: request accepted.
- `data_ok` in 1: response valid.
- `data_rdata` in 32: response data.
- `mem_stall` out 1: hold EX/MEM and all upstream stages.
- `mem_ldata` out 32: extended load result. It is valid while `mem_done`=1.
- `mem_done` out 1: the access has completed for the instruction currently in MEM.

## Operation
- **Access condition.** `go = mem_data_en & (mem_ex == 0) & !refresh`.
- **State IDLE.**
  - `data_req = go`.
  - On `go & data_addr_ok`: go to WAIT.
  - On `go & !data_addr_ok`: stay in IDLE with the request held.
  - `mem_stall = go`.
- **State WAIT.**
  - `data_req = 0`, `mem_stall = 1`.
  - On `data_ok`: register `data_rdata` into `rdata_q` and go to DONE.
  - On `refresh & !data_ok`: go to DRAIN.
  - On `refresh & data_ok`: discard the response and go to IDLE.
- **State DONE.**
  - `mem_done = 1`, `mem_stall = 0`.
  - On `!stall_in`: go to IDLE, because the next instruction enters MEM.
  - On `refresh`: go to IDLE.
- **State DRAIN.**
  - `mem_stall = 1`, no request.
  - On `data_ok`: discard the response and go to IDLE.
  - This state exists because an accepted request cannot be cancelled.
- **Request fields** are combinational from the EX/MEM fields and are held stable while `data_req`=1 (EX/MEM is stalled).
  - `data_wr = |mem_data_wen`.
  - `data_addr = mem_res`.
  - `data_wstrb = mem_data_wen`.
  - `data_wdata = mem_wdata`.
- **Size.** The size is taken from the mask in use: `mem_data_wen` for stores, otherwise `mem_data_ren`.
  - Popcount 1 gives size 0.
  - Masks 0011 or 1100 give size 1.
  - Mask 1111 gives size 2.
- **Load extraction.** The lane is selected by `mem_res[1:0]`.
  - Byte: `rdata_q[8*off +: 8]`, extended to 32 bits per `mem_loadX`.
  - Half: `rdata_q[16*off[1] +: 16]`, extended per `mem_loadX`.
  - Word: passed through unchanged.
- **Stores** complete on `data_ok` exactly as loads do. `mem_ldata` is don't-care for stores.
- **No access.** With `mem_ex != 0` or `mem_data_en = 0`: no request is issued, `mem_stall = 0` and `mem_done = 0`.

## Timing
- **Reset.** State is IDLE and `rdata_q = 0`. With `mem_data_en` low this gives `data_req = 0`, `mem_stall = 0`, `mem_done = 0` and `mem_ldata = 0`.
- **Reset mid-access** (WAIT or DRAIN) forces IDLE. Bus-side recovery belongs to the bus reset.
- **Best-case latency.**
  - Cycle 0: `data_req` and `data_addr_ok`.
  - Cycle 1: `data_ok`.
  - Cycle 2: DONE, with `mem_stall` low and `mem_ldata` valid.
- **Response ordering.** `data_ok` is never expected in the same cycle as its own `addr_ok`. A `data_ok` arriving in IDLE or DONE is ignored.
- **Handshake rule.** Once `data_req` is raised, the request fields are held stable until `addr_ok`. The only exception is `refresh`, which drops the request in that same cycle.
- **Stalled in DONE.** DONE persists for as many cycles as `stall_in` stays high, with the result held constant. There is no re-issue.

## Structure
- **Shared package / header:**
  - State encodings (IDLE=0, WAIT=1, DONE=2, DRAIN=3).
  - Size codes (`SZ_B`, `SZ_H`, `SZ_W`).
  - `EXBITS`/`NUM_EX`, reused from the existing defines.
- **Sub-module `load_align`** (combinational): inputs `rdata`, `ren[3:0]`, `off[1:0]`, `loadX`; output is the 32-bit extended data.
- **Top level** holds only the state register, `rdata_q` and the request decode.

## Test plan
- **LB sign-extend.** Load with ren=0100, addr=…02, loadX=1, rdata=0x00A50000, addr_ok on the first cycle, data_ok one cycle later → `mem_ldata`=0xFFFFFFA5; `mem_stall` is high for 2 cycles.
- **LHU with address back-pressure.** Load with ren=1100, addr=…02, loadX=0, rdata=0x8001xxxx, addr_ok delayed 3 cycles → request fields stable for 4 cycles, size=1, result 0x00008001.
- **Word store.** SW with wen=1111, wdata=0xDEADBEEF → data_wr=1, size=2, wstrb=1111; DONE one cycle after data_ok.
- **Refresh while waiting.** refresh asserted in WAIT, data_ok arrives 2 cycles later → DRAIN; `mem_stall` stays high until data_ok; no `mem_done`; then IDLE.
- **Exception suppresses access.** mem_ex=non-zero with data_en=1 → `data_req` never asserted, `mem_stall`=0.
- **Reset mid-access.** resetn low during WAIT → next cycle IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_pkg
//  Description : Shared types and constants for the memory-access stage:
//                FSM state encoding, access-size codes, exception-vector
//                width and the byte-mask to size decode helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef NUM_EX
`define NUM_EX 16
`endif

package mem_access_stage_pkg;

    localparam int NUM_EX = `NUM_EX;

    // Exception vector of the instruction in MEM (EXBITS = NUM_EX-1:0)
    typedef logic [NUM_EX-1:0] exbits_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Only the legal masks are decoded; any single-lane mask is a byte.
    function automatic logic [1:0] mask_size(input logic [3:0] mask);
        case (mask)
            4'b1111:          mask_size = SZ_W;
            4'b0011, 4'b1100: mask_size = SZ_H;
            default:          mask_size = SZ_B;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_if
//  Description : Bundle of the EX/MEM access fields, the data-side bus
//                request/response handshake and the stage results.
//  Ports       : slave  - the memory-access stage (consumes EX/MEM fields and
//                         bus responses, drives request and results)
//                master - the environment (pipeline + data bus)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    // pipeline side
    logic        refresh;
    logic        stall_in;
    exbits_t     mem_ex;
    logic [31:0] mem_res;
    logic        mem_data_en;
    logic [3:0]  mem_data_ren;
    logic [3:0]  mem_data_wen;
    logic [31:0] mem_wdata;
    logic        mem_loadX;

    // data bus
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_ok;
    logic [31:0] data_rdata;

    // results
    logic        mem_stall;
    logic [31:0] mem_ldata;
    logic        mem_done;

    modport slave (
        input  refresh, stall_in, mem_ex, mem_res, mem_data_en, mem_data_ren,
               mem_data_wen, mem_wdata, mem_loadX,
               data_addr_ok, data_ok, data_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               mem_stall, mem_ldata, mem_done
    );

    modport master (
        output refresh, stall_in, mem_ex, mem_res, mem_data_en, mem_data_ren,
               mem_data_wen, mem_wdata, mem_loadX,
               data_addr_ok, data_ok, data_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               mem_stall, mem_ldata, mem_done
    );

endinterface

`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_load_align
//  Description : Combinational load aligner. Picks the byte/half lane given
//                by the address offset and sign- or zero-extends it to 32
//                bits; words pass through unchanged.
//  Ports       : rdata_i [31:0] raw response word
//                ren_i   [3:0]  byte-lane read mask (selects access size)
//                off_i   [1:0]  address offset within the word
//                loadx_i        1 = sign-extend, 0 = zero-extend
//                data_o  [31:0] aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  wire logic [31:0] rdata_i,
    input  wire logic [3:0]  ren_i,
    input  wire logic [1:0]  off_i,
    input  wire logic        loadx_i,
    output logic      [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane position comes from the address, not from the mask bits.
    assign w_byte = rdata_i[{off_i, 3'b000} +: 8];
    assign w_half = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = rdata_i;
        case (mask_size(ren_i))
            SZ_B:    data_o = {{24{loadx_i & w_byte[7]}}, w_byte};
            SZ_H:    data_o = {{16{loadx_i & w_half[15]}}, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Memory-access pipeline stage. Issues the data-side request
//                for the instruction in MEM, stalls the pipeline while the
//                access is outstanding and presents the aligned load result
//                once the response has returned.
//  Ports       : clk_i    clock, rising edge
//                resetn_i synchronous active-low reset
//                bus      mem_access_stage_if.slave - EX/MEM fields, data bus
//                         handshake, mem_stall / mem_ldata / mem_done
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  wire logic         clk_i,
    input  wire logic         resetn_i,
    mem_access_stage_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        w_go;
    logic        w_idle;

    assign w_go   = bus.mem_data_en & (bus.mem_ex == '0) & ~bus.refresh;
    assign w_idle = (state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_go && bus.data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.data_ok) begin
                    if (bus.refresh) begin
                        // flushed instruction: response is dropped
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = bus.data_rdata;
                        state_d = ST_DONE;
                    end
                end else if (bus.refresh) begin
                    // accepted request cannot be withdrawn; absorb its response
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!bus.stall_in || bus.refresh) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Request decode: fields follow EX/MEM, which is frozen by mem_stall
    // while the request is pending.
    // ------------------------------------------------------------------
    assign bus.data_req   = w_idle & w_go;
    assign bus.data_wr    = |bus.mem_data_wen;
    assign bus.data_size  = mask_size(bus.data_wr ? bus.mem_data_wen : bus.mem_data_ren);
    assign bus.data_addr  = bus.mem_res;
    assign bus.data_wstrb = bus.mem_data_wen;
    assign bus.data_wdata = bus.mem_wdata;

    assign bus.mem_stall  = w_idle ? w_go : (state_q != ST_DONE);
    assign bus.mem_done   = (state_q == ST_DONE);

    mem_access_stage_load_align u_load_align (
        .rdata_i (rdata_q),
        .ren_i   (bus.mem_data_ren),
        .off_i   (bus.mem_res[1:0]),
        .loadx_i (bus.mem_loadX),
        .data_o  (bus.mem_ldata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Self-checking bench for mem_access_stage: decode table,
//                full-access table and hand-written flush/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rdata = 32'h0;

    typedef struct {
        logic        en;
        exbits_t     ex;
        logic        refresh;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic        stall;
    } dec_vec_t;

    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic        loadx;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          delay;
        logic [1:0]  size;
        logic [31:0] exp;
        logic        chk_ld;
    } acc_vec_t;

    dec_vec_t dv [7];
    acc_vec_t av [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.refresh      = 1'b0;
        bus.stall_in     = 1'b0;
        bus.mem_ex       = '0;
        bus.mem_res      = 32'h0;
        bus.mem_data_en  = 1'b0;
        bus.mem_data_ren = 4'b1111;
        bus.mem_data_wen = 4'b0000;
        bus.mem_wdata    = 32'h0;
        bus.mem_loadX    = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_ok      = 1'b0;
        bus.data_rdata   = 32'h0;
    endtask

    // Full access: optional addr_ok back-pressure, data_ok one cycle after
    // acceptance, one stalled DONE cycle, then release.
    task automatic run_access(input acc_vec_t v);
        int stall_cycles;
        stall_cycles = 0;
        bus.mem_data_en  = 1'b1;
        bus.mem_ex       = '0;
        bus.mem_res      = v.addr;
        bus.mem_data_ren = v.ren;
        bus.mem_data_wen = v.wen;
        bus.mem_wdata    = v.wdata;
        bus.mem_loadX    = v.loadx;
        bus.data_addr_ok = 1'b0;
        #1;
        for (int k = 0; k < v.delay; k++) begin
            chk("req_held",  {31'b0, bus.data_req}, 32'd1);
            chk("addr_held", bus.data_addr, v.addr);
            chk("size_held", {30'b0, bus.data_size}, {30'b0, v.size});
            if (bus.mem_stall) stall_cycles++;
            step();
        end
        bus.data_addr_ok = 1'b1;
        #1;
        chk("req",   {31'b0, bus.data_req}, 32'd1);
        chk("size",  {30'b0, bus.data_size}, {30'b0, v.size});
        chk("wr",    {31'b0, bus.data_wr}, {31'b0, |v.wen});
        chk("wstrb", {28'b0, bus.data_wstrb}, {28'b0, v.wen});
        chk("wdata", bus.data_wdata, v.wdata);
        if (bus.mem_stall) stall_cycles++;
        step();
        bus.data_addr_ok = 1'b0;
        #1;
        chk("wait_req", {31'b0, bus.data_req}, 32'd0);
        if (bus.mem_stall) stall_cycles++;
        bus.data_ok    = 1'b1;
        bus.data_rdata = v.rdata;
        step();
        bus.data_ok    = 1'b0;
        bus.data_rdata = 32'h5A5A5A5A;
        last_rdata     = v.rdata;
        #1;
        chk("done",         {31'b0, bus.mem_done}, 32'd1);
        chk("done_stall",   {31'b0, bus.mem_stall}, 32'd0);
        chk("stall_cycles", stall_cycles, v.delay + 2);
        if (v.chk_ld) chk("ldata", bus.mem_ldata, v.exp);
        bus.stall_in = 1'b1;
        step();
        chk("done_held", {31'b0, bus.mem_done}, 32'd1);
        chk("req_in_done", {31'b0, bus.data_req}, 32'd0);
        if (v.chk_ld) chk("ldata_held", bus.mem_ldata, v.exp);
        bus.stall_in    = 1'b0;
        bus.mem_data_en = 1'b0;
        step();
        chk("release_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("release_stall", {31'b0, bus.mem_stall}, 32'd0);
    endtask

    // Bring a word load to WAIT with acceptance on the first cycle.
    task automatic enter_wait(input logic [31:0] addr);
        bus.mem_data_en  = 1'b1;
        bus.mem_res      = addr;
        bus.mem_data_ren = 4'b1111;
        bus.mem_data_wen = 4'b0000;
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           en    ex     ref   ren      wen      req   wr    size  stall
        dv[0] = '{1'b1, 'd0,  1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1};
        dv[1] = '{1'b1, 'd0,  1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1};
        dv[2] = '{1'b1, 'd0,  1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
        dv[3] = '{1'b1, 'd4,  1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        dv[4] = '{1'b0, 'd0,  1'b0, 4'b1100, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
        dv[5] = '{1'b1, 'd0,  1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
        dv[6] = '{1'b1, 'd1,  1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b0};

        //           ren      wen      addr          lx    rdata          wdata          dly size  exp            chk
        av[0] = '{4'b0100, 4'b0000, 32'h1000_0002, 1'b1, 32'h00A5_0000, 32'h0,         0, 2'd0, 32'hFFFF_FFA5, 1'b1};
        av[1] = '{4'b1100, 4'b0000, 32'h2000_0002, 1'b0, 32'h8001_1234, 32'h0,         3, 2'd1, 32'h0000_8001, 1'b1};
        av[2] = '{4'b0000, 4'b1111, 32'h3000_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 2'd2, 32'h0,         1'b0};
        av[3] = '{4'b0001, 4'b0000, 32'h1000_0000, 1'b0, 32'h1234_56F0, 32'h0,         0, 2'd0, 32'h0000_00F0, 1'b1};
        av[4] = '{4'b1000, 4'b0000, 32'h1000_0003, 1'b1, 32'h7F00_0000, 32'h0,         1, 2'd0, 32'h0000_007F, 1'b1};
        av[5] = '{4'b0011, 4'b0000, 32'h1000_0000, 1'b1, 32'h0000_8000, 32'h0,         0, 2'd1, 32'hFFFF_8000, 1'b1};
        av[6] = '{4'b1111, 4'b0000, 32'h1000_0004, 1'b1, 32'hCAFE_BABE, 32'h0,         0, 2'd2, 32'hCAFE_BABE, 1'b1};
        av[7] = '{4'b0010, 4'b0000, 32'h1000_0001, 1'b0, 32'h0000_9900, 32'h0,         2, 2'd0, 32'h0000_0099, 1'b1};

        // ---------------- reset state ----------------
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        chk("rst_req",   {31'b0, bus.data_req}, 32'd0);
        chk("rst_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("rst_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("rst_ldata", bus.mem_ldata, 32'h0);
        resetn = 1'b1;
        step();

        // ---------------- request decode in IDLE ----------------
        for (int i = 0; i < 7; i++) begin
            bus.mem_data_en  = dv[i].en;
            bus.mem_ex       = dv[i].ex;
            bus.refresh      = dv[i].refresh;
            bus.mem_data_ren = dv[i].ren;
            bus.mem_data_wen = dv[i].wen;
            bus.mem_res      = 32'h0000_1000 + i;
            #1;
            chk("dec_req",   {31'b0, bus.data_req}, {31'b0, dv[i].req});
            chk("dec_wr",    {31'b0, bus.data_wr}, {31'b0, dv[i].wr});
            chk("dec_size",  {30'b0, bus.data_size}, {30'b0, dv[i].size});
            chk("dec_stall", {31'b0, bus.mem_stall}, {31'b0, dv[i].stall});
            chk("dec_done",  {31'b0, bus.mem_done}, 32'd0);
            chk("dec_addr",  bus.data_addr, 32'h0000_1000 + i);
            #1;
        end
        idle_inputs();
        step();

        // ---------------- complete accesses ----------------
        for (int i = 0; i < 8; i++) begin
            run_access(av[i]);
            idle_inputs();
            step();
        end

        // ---------------- refresh while waiting -> DRAIN ----------------
        enter_wait(32'h4000_0000);
        bus.refresh = 1'b1;
        #1;
        chk("flush_wait_stall", {31'b0, bus.mem_stall}, 32'd1);
        chk("flush_wait_req",   {31'b0, bus.data_req}, 32'd0);
        step();
        bus.refresh     = 1'b0;
        bus.mem_data_en = 1'b0;
        #1;
        chk("drain_stall", {31'b0, bus.mem_stall}, 32'd1);
        chk("drain_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("drain_req",   {31'b0, bus.data_req}, 32'd0);
        step();
        chk("drain_stall2", {31'b0, bus.mem_stall}, 32'd1);
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'hFFFF_FFFF;
        #1;
        chk("drain_stall3", {31'b0, bus.mem_stall}, 32'd1);
        step();
        bus.data_ok = 1'b0;
        #1;
        chk("drain_exit_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("drain_exit_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("drain_discard",    bus.mem_ldata, last_rdata);
        idle_inputs();
        step();

        // ---------------- refresh together with data_ok in WAIT ----------------
        enter_wait(32'h4000_0010);
        bus.refresh    = 1'b1;
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'h1111_1111;
        step();
        bus.refresh     = 1'b0;
        bus.data_ok     = 1'b0;
        bus.mem_data_en = 1'b0;
        #1;
        chk("flush_ok_stall",   {31'b0, bus.mem_stall}, 32'd0);
        chk("flush_ok_done",    {31'b0, bus.mem_done}, 32'd0);
        chk("flush_ok_discard", bus.mem_ldata, last_rdata);
        idle_inputs();
        step();

        // ---------------- refresh in IDLE drops the request ----------------
        bus.mem_data_en  = 1'b1;
        bus.refresh      = 1'b1;
        bus.data_addr_ok = 1'b1;
        #1;
        chk("flush_idle_req",   {31'b0, bus.data_req}, 32'd0);
        chk("flush_idle_stall", {31'b0, bus.mem_stall}, 32'd0);
        step();
        idle_inputs();
        #1;
        chk("flush_idle_no_wait", {31'b0, bus.mem_stall}, 32'd0);
        step();

        // ---------------- refresh in DONE while stalled ----------------
        enter_wait(32'h5000_0000);
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'h2468_ACE0;
        step();
        bus.data_ok = 1'b0;
        last_rdata  = 32'h2468_ACE0;
        #1;
        chk("done2",       {31'b0, bus.mem_done}, 32'd1);
        chk("done2_ldata", bus.mem_ldata, 32'h2468_ACE0);
        bus.stall_in = 1'b1;
        bus.refresh  = 1'b1;
        step();
        idle_inputs();
        bus.stall_in = 1'b1;
        #1;
        chk("flush_done_exit", {31'b0, bus.mem_done}, 32'd0);
        idle_inputs();
        step();

        // ---------------- exception suppresses access ----------------
        bus.mem_data_en  = 1'b1;
        bus.mem_ex       = 'd16;
        bus.mem_data_ren = 4'b0001;
        bus.data_addr_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ex_req",   {31'b0, bus.data_req}, 32'd0);
            chk("ex_stall", {31'b0, bus.mem_stall}, 32'd0);
            step();
        end
        idle_inputs();
        step();

        // ---------------- stray data_ok in IDLE ----------------
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'hBAD0_BAD0;
        step();
        bus.data_ok = 1'b0;
        #1;
        chk("stray_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("stray_ldata", bus.mem_ldata, last_rdata);
        step();

        // ---------------- reset mid-access ----------------
        enter_wait(32'h6000_0000);
        bus.mem_data_en = 1'b0;
        #1;
        chk("pre_rst_stall", {31'b0, bus.mem_stall}, 32'd1);
        resetn = 1'b0;
        step();
        chk("midrst_req",   {31'b0, bus.data_req}, 32'd0);
        chk("midrst_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("midrst_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("midrst_ldata", bus.mem_ldata, 32'h0);
        resetn = 1'b1;
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'h7777_7777;
        step();
        bus.data_ok = 1'b0;
        #1;
        chk("post_rst_done",  {31'b0, bus.mem_done}, 32'd0);
        chk("post_rst_stall", {31'b0, bus.mem_stall}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
